// File: rtl/dram_req_queue.sv
// dram_req_queue
// In-order request buffer between the memory controller (upstream) and the
// dram model (downstream). Controller read/write bursts are stored in a
// DEPTH-entry FIFO and issued to dram one at a time; read data and write
// completions are returned to the controller in issue order.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   mem_addr/mem_read_en/
//   mem_write_en/mem_wdata        controller request (1-cycle enable pulses)
//   mem_ready                     queue can accept a request (combinational)
//   mem_complete                  write completion pulse
//   mem_rdata/mem_valid           read data and its valid pulse
//   dram_addr/dram_read_en/
//   dram_write_en/dram_wdata      issued request (1-cycle enable pulses)
//   dram_ready                    dram can accept a request
//   dram_complete                 dram write done pulse
//   dram_rdata/dram_valid         dram read data and its valid pulse
//   occupancy                     queued entries, not counting the in-flight one
//   err                           sticky protocol error, cleared only by rst
module dram_req_queue #(
    parameter int ADDRESS_LEN        = 32,
    parameter int BURST_ACCESS_WIDTH = 256,
    parameter int DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [ADDRESS_LEN-1:0]        mem_addr,
    input  logic                          mem_read_en,
    input  logic                          mem_write_en,
    input  logic [BURST_ACCESS_WIDTH-1:0] mem_wdata,
    output logic                          mem_ready,
    output logic                          mem_complete,
    output logic [BURST_ACCESS_WIDTH-1:0] mem_rdata,
    output logic                          mem_valid,
    output logic [ADDRESS_LEN-1:0]        dram_addr,
    output logic                          dram_read_en,
    output logic                          dram_write_en,
    output logic [BURST_ACCESS_WIDTH-1:0] dram_wdata,
    input  logic                          dram_ready,
    input  logic                          dram_complete,
    input  logic [BURST_ACCESS_WIDTH-1:0] dram_rdata,
    input  logic                          dram_valid,
    output logic [$clog2(DEPTH+1)-1:0]    occupancy,
    output logic                          err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = $clog2(DEPTH+1);
    localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT_RD, WAIT_WR} state_t;

    // FIFO storage, one entry = {is_write, addr, wdata}
    logic                          r_fifo_wr   [DEPTH];
    logic [ADDRESS_LEN-1:0]        r_fifo_addr [DEPTH];
    logic [BURST_ACCESS_WIDTH-1:0] r_fifo_data [DEPTH];

    logic [PTR_W-1:0]              r_wr_ptr;
    logic [PTR_W-1:0]              r_rd_ptr;
    logic [OCC_W-1:0]              r_occ;
    logic                          r_err;
    state_t                        r_state;

    logic                          r_dram_read_en;
    logic                          r_dram_write_en;
    logic [ADDRESS_LEN-1:0]        r_dram_addr;
    logic [BURST_ACCESS_WIDTH-1:0] r_dram_wdata;
    logic                          r_mem_valid;
    logic                          r_mem_complete;
    logic [BURST_ACCESS_WIDTH-1:0] r_mem_rdata;

    logic w_req;
    logic w_push;
    logic w_pop;
    logic w_req_err;
    logic w_rsp_err;

    // A full queue refuses input even when the head is popped this cycle.
    assign mem_ready = (r_occ != FULL_OCC) && !rst;

    assign w_req  = mem_read_en | mem_write_en;
    assign w_push = w_req && mem_ready;
    assign w_pop  = (r_state == IDLE) && (r_occ != '0) && dram_ready;

    // Conflicting enables keep the write; any refused request is an error.
    assign w_req_err = (mem_read_en && mem_write_en) || (w_req && !mem_ready);

    // A response the FSM is not waiting for is dropped and flagged.
    assign w_rsp_err = (dram_valid    && (r_state != WAIT_RD)) ||
                       (dram_complete && (r_state != WAIT_WR));

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_wr[r_wr_ptr]   <= mem_write_en;
            r_fifo_addr[r_wr_ptr] <= mem_addr;
            r_fifo_data[r_wr_ptr] <= mem_write_en ? mem_wdata : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
            if (w_req_err || w_rsp_err) r_err <= 1'b1;
        end
    end

    // Issue FSM: one request outstanding at dram, outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= IDLE;
            r_dram_read_en  <= 1'b0;
            r_dram_write_en <= 1'b0;
            r_dram_addr     <= '0;
            r_dram_wdata    <= '0;
            r_mem_valid     <= 1'b0;
            r_mem_complete  <= 1'b0;
            r_mem_rdata     <= '0;
        end else begin
            r_dram_read_en  <= 1'b0;
            r_dram_write_en <= 1'b0;
            r_mem_valid     <= 1'b0;
            r_mem_complete  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_pop) begin
                        r_dram_addr  <= r_fifo_addr[r_rd_ptr];
                        r_dram_wdata <= r_fifo_data[r_rd_ptr];
                        if (r_fifo_wr[r_rd_ptr]) begin
                            r_dram_write_en <= 1'b1;
                            r_state         <= WAIT_WR;
                        end else begin
                            r_dram_read_en  <= 1'b1;
                            r_state         <= WAIT_RD;
                        end
                    end
                end
                WAIT_RD: begin
                    if (dram_valid) begin
                        r_mem_rdata <= dram_rdata;
                        r_mem_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                WAIT_WR: begin
                    if (dram_complete) begin
                        r_mem_complete <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem_complete  = r_mem_complete;
    assign mem_rdata     = r_mem_rdata;
    assign mem_valid     = r_mem_valid;
    assign dram_addr     = r_dram_addr;
    assign dram_read_en  = r_dram_read_en;
    assign dram_write_en = r_dram_write_en;
    assign dram_wdata    = r_dram_wdata;
    assign occupancy     = r_occ;
    assign err           = r_err;

endmodule

// File: tb/tb_dram_req_queue.sv
module tb_dram_req_queue;

    localparam int AW = 16;
    localparam int DW = 32;
    localparam int DEPTH = 4;

    logic          clk;
    logic          rst;
    logic [AW-1:0] mem_addr;
    logic          mem_read_en;
    logic          mem_write_en;
    logic [DW-1:0] mem_wdata;
    logic          mem_ready;
    logic          mem_complete;
    logic [DW-1:0] mem_rdata;
    logic          mem_valid;
    logic [AW-1:0] dram_addr;
    logic          dram_read_en;
    logic          dram_write_en;
    logic [DW-1:0] dram_wdata;
    logic          dram_ready;
    logic          dram_complete;
    logic [DW-1:0] dram_rdata;
    logic          dram_valid;
    logic [2:0]    occupancy;
    logic          err;

    logic          rsp_valid, rsp_complete, stray_valid, stray_complete;
    logic [DW-1:0] rsp_rdata;

    assign dram_valid    = rsp_valid | stray_valid;
    assign dram_complete = rsp_complete | stray_complete;
    assign dram_rdata    = rsp_rdata;

    dram_req_queue #(.ADDRESS_LEN(AW), .BURST_ACCESS_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .mem_addr(mem_addr), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_complete(mem_complete),
        .mem_rdata(mem_rdata), .mem_valid(mem_valid),
        .dram_addr(dram_addr), .dram_read_en(dram_read_en), .dram_write_en(dram_write_en),
        .dram_wdata(dram_wdata), .dram_ready(dram_ready), .dram_complete(dram_complete),
        .dram_rdata(dram_rdata), .dram_valid(dram_valid),
        .occupancy(occupancy), .err(err)
    );

    typedef struct packed {
        logic          wr;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } req_t;

    req_t exp_issue[$];
    req_t exp_resp[$];

    int   cyc;
    int   n_total, n_bad;
    int   n_valid, n_complete;
    int   req_cyc, issue_cyc, resp_cyc, dv_cyc;
    logic outstanding;
    logic rsp_auto;

    function automatic logic [DW-1:0] rd_pat(input logic [AW-1:0] a);
        return {16'hA5A5, a};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Caller is at posedge+1; drives one request cycle and returns at the next posedge+1.
    task automatic drive(input logic rd, input logic wr, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic accept);
        req_t e;
        mem_read_en  = rd;
        mem_write_en = wr;
        mem_addr     = a;
        mem_wdata    = d;
        req_cyc      = cyc;
        if (accept) begin
            e.wr   = wr;
            e.addr = a;
            e.data = wr ? d : rd_pat(a);
            exp_issue.push_back(e);
            exp_resp.push_back(e);
        end
        @(posedge clk); #1;
        mem_read_en  = 1'b0;
        mem_write_en = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int i = 0; i < budget && (exp_issue.size() != 0 || exp_resp.size() != 0); i++)
            @(negedge clk);
        chk("drain", 64'(exp_issue.size() + exp_resp.size()), 0);
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        exp_issue.delete();
        exp_resp.delete();
        outstanding = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clk = 1'b0;
        cyc = 0;
        forever begin
            #5 clk = 1'b1;
            cyc++;
            #5 clk = 1'b0;
        end
    end

    initial begin
        int t0, c0, v0;
        rst = 1'b1;
        mem_addr = '0; mem_read_en = 1'b0; mem_write_en = 1'b0; mem_wdata = '0;
        dram_ready = 1'b1;
        rsp_valid = 1'b0; rsp_complete = 1'b0; rsp_rdata = '0;
        stray_valid = 1'b0; stray_complete = 1'b0;
        n_total = 0; n_bad = 0; n_valid = 0; n_complete = 0;
        req_cyc = 0; issue_cyc = 0; resp_cyc = 0; dv_cyc = 0;
        outstanding = 1'b0;
        rsp_auto = 1'b1;

        fork
            // output monitor / scoreboard
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (mem_valid || mem_complete) begin
                        if (exp_resp.size() == 0) begin
                            chk("resp_unexpected", 1, 0);
                        end else begin
                            req_t e;
                            e = exp_resp.pop_front();
                            chk("resp_kind", mem_complete, e.wr);
                            if (mem_valid) chk("resp_rdata", mem_rdata, e.data);
                        end
                        if (mem_valid) n_valid++;
                        if (mem_complete) n_complete++;
                        outstanding = 1'b0;
                        resp_cyc = cyc;
                    end
                    if (dram_read_en || dram_write_en) begin
                        chk("one_outstanding", outstanding, 0);
                        if (exp_issue.size() == 0) begin
                            chk("issue_unexpected", 1, 0);
                        end else begin
                            req_t e;
                            e = exp_issue.pop_front();
                            chk("issue_kind", dram_write_en, e.wr);
                            chk("issue_addr", dram_addr, e.addr);
                            if (e.wr) chk("issue_wdata", dram_wdata, e.data);
                        end
                        outstanding = 1'b1;
                        issue_cyc = cyc;
                    end
                end
            end
            // dram responder: answers 3 cycles after each issue
            begin
                logic          pend, pend_wr;
                logic [AW-1:0] pend_addr;
                int            cnt;
                pend = 1'b0; pend_wr = 1'b0; pend_addr = '0; cnt = 0;
                forever begin
                    @(posedge clk); #1;
                    rsp_valid = 1'b0;
                    rsp_complete = 1'b0;
                    if (rst || !rsp_auto) begin
                        pend = 1'b0;
                    end else if (dram_read_en || dram_write_en) begin
                        pend = 1'b1; pend_wr = dram_write_en; pend_addr = dram_addr; cnt = 3;
                    end else if (pend) begin
                        cnt--;
                        if (cnt == 0) begin
                            pend = 1'b0;
                            if (pend_wr) rsp_complete = 1'b1;
                            else begin
                                rsp_valid = 1'b1;
                                rsp_rdata = rd_pat(pend_addr);
                                dv_cyc = cyc;
                            end
                        end
                    end
                end
            end
        join_none

        // reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_mem_ready", mem_ready, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_err", err, 0);
        chk("rst_dram_en", {dram_read_en, dram_write_en}, 0);
        chk("rst_mem_pulses", {mem_valid, mem_complete}, 0);
        chk("rst_dram_addr", dram_addr, 0);
        chk("rst_mem_rdata", mem_rdata, 0);
        rst = 1'b0;
        #1;
        chk("ready_after_rst", mem_ready, 1);
        @(posedge clk); #1;

        // single read latency
        drive(1'b1, 1'b0, 16'h0040, '0, 1'b1);
        t0 = req_cyc;
        wait_drain(50);
        chk("rd_issue_latency", 64'(issue_cyc - t0), 2);
        chk("rd_resp_latency", 64'(resp_cyc - dv_cyc), 1);
        chk("rd_final_rdata", mem_rdata, 32'hA5A5_0040);

        // fill with dram stalled
        dram_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            drive(1'b0, 1'b1, 16'(16'h0100 + i), 32'(32'hD000_0000 + i), 1'b1);
        chk("fill_occupancy", occupancy, 4);
        chk("fill_mem_ready", mem_ready, 0);
        chk("fill_err_before", err, 0);
        drive(1'b0, 1'b1, 16'h0199, 32'hDEAD_BEEF, 1'b0);
        chk("fill_err_after", err, 1);
        chk("fill_occupancy_kept", occupancy, 4);
        c0 = n_complete;
        dram_ready = 1'b1;
        wait_drain(200);
        chk("fill_completes", 64'(n_complete - c0), 4);
        chk("fill_drained_occ", occupancy, 0);

        // mixed order, back to back
        do_reset();
        chk("mix_err_cleared", err, 0);
        drive(1'b0, 1'b1, 16'h0010, 32'h1111_0010, 1'b1);
        drive(1'b1, 1'b0, 16'h0020, '0, 1'b1);
        drive(1'b0, 1'b1, 16'h0030, 32'h3333_0030, 1'b1);
        drive(1'b1, 1'b0, 16'h0040, '0, 1'b1);
        wait_drain(200);
        chk("mix_err", err, 0);
        chk("mix_occupancy", occupancy, 0);

        // both enables at once: write wins
        drive(1'b1, 1'b1, 16'h0080, 32'hCAFE_0080, 1'b1);
        wait_drain(50);
        chk("both_en_err", err, 1);

        // stray dram_complete while idle
        do_reset();
        c0 = n_complete;
        stray_complete = 1'b1;
        @(posedge clk); #1;
        stray_complete = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("stray_err", err, 1);
        chk("stray_no_complete", 64'(n_complete - c0), 0);

        // reset while waiting for a read with two entries queued
        do_reset();
        rsp_auto = 1'b0;
        drive(1'b1, 1'b0, 16'h0100, '0, 1'b1);
        drive(1'b1, 1'b0, 16'h0104, '0, 1'b1);
        drive(1'b1, 1'b0, 16'h0108, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        chk("wait_rd_occupancy", occupancy, 2);
        v0 = n_valid;
        do_reset();
        chk("flush_occupancy", occupancy, 0);
        chk("flush_err", err, 0);
        stray_valid = 1'b1;
        @(posedge clk); #1;
        stray_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("late_valid_err", err, 1);
        chk("flush_no_valid", 64'(n_valid - v0), 0);
        rsp_auto = 1'b1;
        drive(1'b1, 1'b0, 16'h0200, '0, 1'b1);
        wait_drain(50);
        chk("post_flush_read", 64'(n_valid - v0), 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got=%0d exp=%0d", cyc, 0);
        $fatal(1, "timeout");
    end

endmodule
